mem_access_ctrl: RTL and testbench

- Initiator side of the byte-addressed data-memory interface (MemRead/MemWrite/addr/wd/rd).
- The pipeline MEM stage hands it one load or store at a time over a valid/ready request channel.
- It drives the memory port, does sign/zero extension for sub-word loads, and does read-modify-write for sub-word stores.
- It returns the result over a valid/ready response channel and stalls the pipeline while busy.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_lane_merge.sv | 65 ++++++
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory access controller: op codes, FSM states,
// access sizes, lane constants and small op-decoding helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SB  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic       LANE_H0 = 1'b0;
    localparam logic       LANE_H1 = 1'b1;

    function automatic logic is_store(input op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_e op_size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_signed(input op_e op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Lane steering for sub-word accesses: merges store data into a memory word and
// extracts a (sign/zero-extended) load value from it.
module mem_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [15:0] data_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        sign_i,
    output logic [31:0] merged_o,
    output logic [31:0] extracted_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        merged_o    = word_i;
        extracted_o = word_i;
        byte_sel    = word_i[7:0];
        half_sel    = word_i[15:0];

        case (lane_i)
            LANE_B0: byte_sel = word_i[7:0];
            LANE_B1: byte_sel = word_i[15:8];
            LANE_B2: byte_sel = word_i[23:16];
            LANE_B3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase

        case (lane_i[1])
            LANE_H0: half_sel = word_i[15:0];
            LANE_H1: half_sel = word_i[31:16];
            default: half_sel = word_i[15:0];
        endcase

        case (size_i)
            SZ_BYTE: begin
                case (lane_i)
                    LANE_B0: merged_o[7:0]   = data_i[7:0];
                    LANE_B1: merged_o[15:8]  = data_i[7:0];
                    LANE_B2: merged_o[23:16] = data_i[7:0];
                    LANE_B3: merged_o[31:24] = data_i[7:0];
                    default: merged_o        = word_i;
                endcase
                extracted_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                case (lane_i[1])
                    LANE_H0: merged_o[15:0]  = data_i;
                    LANE_H1: merged_o[31:16] = data_i;
                    default: merged_o        = word_i;
                endcase
                extracted_o = {{16{sign_i & half_sel[15]}}, half_sel};
            end
            default: begin
                merged_o    = word_i;
                extracted_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: accepts one load/store at a time, drives a registered
// word-aligned memory port, and returns an extended result or an error.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] addr,
    output logic [31:0] wd,
    input  logic [31:0] rd
);

    state_e      state_q;
    op_e         op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;

    op_e         req_op_d;
    size_e       req_size_d;
    logic [32:0] last_byte_d;
    logic        misaligned_d;
    logic        req_err_d;
    logic [31:0] merged_d;
    logic [31:0] extracted_d;

    assign req_op_d   = op_e'(req_op);
    assign req_size_d = op_size(req_op_d);

    // Computed in 33 bits so an address near 2^32 cannot wrap into range.
    assign last_byte_d  = {1'b0, req_addr} + {30'd0, size_bytes(req_size_d) - 3'd1};
    assign misaligned_d = ((req_size_d == SZ_HALF) && req_addr[0]) ||
                          ((req_size_d == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign req_err_d    = misaligned_d || (last_byte_d >= 33'(MEM_BYTES));

    mem_lane_merge u_lane (
        .word_i      (rd),
        .data_i      (wdata_q),
        .lane_i      (lane_q),
        .size_i      (op_size(op_q)),
        .sign_i      (op_signed(op_q)),
        .merged_o    (merged_d),
        .extracted_o (extracted_d)
    );

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_LB;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= 32'h0;
            wd_q         <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op_d;
                        lane_q      <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        req_ready_q <= 1'b0;
                        if (req_err_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (req_op_d == OP_SW) begin
                            state_q     <= WRITE;
                            mem_write_q <= 1'b1;
                            addr_q      <= {req_addr[31:2], 2'b00};
                            wd_q        <= req_wdata;
                        end else begin
                            state_q    <= READ;
                            mem_read_q <= 1'b1;
                            addr_q     <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    mem_read_q <= 1'b0;
                    if (is_store(op_q)) begin
                        state_q     <= WRITE;
                        mem_write_q <= 1'b1;
                        wd_q        <= merged_d;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= extracted_d;
                    end
                end
                WRITE: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign addr       = addr_q;
    assign wd         = wd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 1 KiB byte memory model on the port.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:1023];
    logic       preload;
    int         rd_pulses = 0;
    int         wr_pulses = 0;
    logic [31:0] last_rd_addr = 32'h0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    mem_access_ctrl #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .wd         (wd),
        .rd         (rd)
    );

    always #5 clk = ~clk;

    assign rd = {mem[{addr[9:2], 2'd3}], mem[{addr[9:2], 2'd2}],
                 mem[{addr[9:2], 2'd1}], mem[{addr[9:2], 2'd0}]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem[0]  <= 8'h11; mem[1]  <= 8'h22; mem[2]  <= 8'h83; mem[3]  <= 8'h44;
            mem[8]  <= 8'h78; mem[9]  <= 8'h56; mem[10] <= 8'h34; mem[11] <= 8'h12;
        end else if (MemWrite) begin
            mem[{addr[9:2], 2'd0}] <= wd[7:0];
            mem[{addr[9:2], 2'd1}] <= wd[15:8];
            mem[{addr[9:2], 2'd2}] <= wd[23:16];
            mem[{addr[9:2], 2'd3}] <= wd[31:24];
        end
    end

    always @(negedge clk) begin
        if (MemRead) begin
            rd_pulses++;
            last_rd_addr = addr;
        end
        if (MemWrite) begin
            wr_pulses++;
            last_wr_addr = addr;
            last_wr_data = wd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One full transaction with resp_ready held high; latency counts edges from accept to resp_valid.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr);
        int rd0, wr0, guard;
        rdata = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wdata; resp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout op=%0d addr=%0d", op, a);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        rd0 = rd_pulses; wr0 = wr_pulses;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            total++; bad++;
            $display("FAIL resp_timeout op=%0d addr=%0d", op, a);
        end
        rdata = resp_rdata; err = resp_err;
        nrd = rd_pulses - rd0; nwr = wr_pulses - wr0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_resp got rr=%b rv=%b rd=%h re=%b exp 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        total++;
        if (MemRead !== 1'b0 || MemWrite !== 1'b0 || addr !== 32'h0 || wd !== 32'h0) begin
            bad++;
            $display("FAIL reset_port got mr=%b mw=%b addr=%h wd=%h exp 0 0 0 0", MemRead, MemWrite, addr, wd);
        end
        preload = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_lw();
        logic [31:0] r; logic e; int lat, nrd, nwr;
        run_op(OP_LW, 32'd0, 32'h0, r, e, lat, nrd, nwr);
        total++;
        if (r !== 32'h4483_2211 || e !== 1'b0) begin
            bad++; $display("FAIL lw0 got=%h err=%b exp=44832211 err=0", r, e);
        end
        total++;
        if (lat != 2 || nrd != 1 || nwr != 0 || last_rd_addr !== 32'h0) begin
            bad++; $display("FAIL lw0_timing got lat=%0d rd=%0d wr=%0d raddr=%h exp 2 1 0 0", lat, nrd, nwr, last_rd_addr);
        end
    endtask

    task automatic test_sub_loads();
        logic [2:0]  ops [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LH, OP_LB};
        logic [31:0] adr [6] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd1};
        logic [31:0] exp [6] = '{32'hFFFF_FF83, 32'h0000_0083, 32'h0000_4483,
                                 32'h0000_2211, 32'h0000_2211, 32'h0000_0022};
        logic [31:0] r; logic e; int lat, nrd, nwr;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], adr[i], 32'h0, r, e, lat, nrd, nwr);
            total++;
            if (r !== exp[i] || e !== 1'b0 || lat != 2) begin
                bad++;
                $display("FAIL subload%0d op=%0d addr=%0d got=%h err=%b lat=%0d exp=%h err=0 lat=2",
                         i, ops[i], adr[i], r, e, lat, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'd0; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_op = OP_LBU; req_addr = 32'd2;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h4483_2211 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold%0d got rv=%b rd=%h rr=%b exp 1 44832211 0", i, resp_valid, resp_rdata, req_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || MemRead !== 1'b0) begin
            bad++;
            $display("FAIL post_handshake got rv=%b rr=%b mr=%b exp 0 1 0", resp_valid, req_ready, MemRead);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (MemRead !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL next_accept got mr=%b rr=%b exp 1 0", MemRead, req_ready);
        end
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (resp_rdata !== 32'h0000_0083 || resp_valid !== 1'b1) begin
            bad++; $display("FAIL next_lbu got=%h rv=%b exp=00000083 rv=1", resp_rdata, resp_valid);
        end
        @(posedge clk);
    endtask

    task automatic test_sb();
        logic [31:0] r; logic e; int lat, nrd, nwr;
        run_op(OP_SB, 32'd5, 32'h0000_00AB, r, e, lat, nrd, nwr);
        total++;
        if (lat != 3 || nrd != 1 || nwr != 1 || r !== 32'h0 || e !== 1'b0) begin
            bad++; $display("FAIL sb5 got lat=%0d rd=%0d wr=%0d r=%h err=%b exp 3 1 1 0 0", lat, nrd, nwr, r, e);
        end
        total++;
        if (last_rd_addr !== 32'd4 || last_wr_addr !== 32'd4 || last_wr_data !== 32'h0000_AB00) begin
            bad++; $display("FAIL sb5_port got raddr=%h waddr=%h wd=%h exp 4 4 0000ab00",
                            last_rd_addr, last_wr_addr, last_wr_data);
        end
        run_op(OP_LW, 32'd4, 32'h0, r, e, lat, nrd, nwr);
        total++;
        if (r !== 32'h0000_AB00) begin
            bad++; $display("FAIL sb5_readback got=%h exp=0000ab00", r);
        end
    endtask

    task automatic test_sh_sw();
        logic [31:0] r; logic e; int lat, nrd, nwr;
        run_op(OP_SH, 32'd2, 32'h1234_BEEF, r, e, lat, nrd, nwr);
        total++;
        if (lat != 3 || last_wr_data !== 32'hBEEF_2211 || last_wr_addr !== 32'd0) begin
            bad++; $display("FAIL sh2 got lat=%0d wd=%h waddr=%h exp 3 beef2211 0", lat, last_wr_data, last_wr_addr);
        end
        run_op(OP_LH, 32'd2, 32'h0, r, e, lat, nrd, nwr);
        total++;
        if (r !== 32'hFFFF_BEEF) begin
            bad++; $display("FAIL sh2_lh got=%h exp=ffffbeef", r);
        end
        run_op(OP_SW, 32'd12, 32'hCAFE_F00D, r, e, lat, nrd, nwr);
        total++;
        if (lat != 2 || nrd != 0 || nwr != 1 || last_wr_addr !== 32'd12 || last_wr_data !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL sw12 got lat=%0d rd=%0d wr=%0d waddr=%h wd=%h exp 2 0 1 c cafef00d",
                            lat, nrd, nwr, last_wr_addr, last_wr_data);
        end
        run_op(OP_LW, 32'd12, 32'h0, r, e, lat, nrd, nwr);
        total++;
        if (r !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL sw12_readback got=%h exp=cafef00d", r);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ops [7] = '{OP_LW, OP_SW, OP_LH, OP_LB, OP_LH, OP_SH, OP_SB};
        logic [31:0] adr [7] = '{32'd6, 32'd1022, 32'd1, 32'd1024, 32'd1023, 32'd1023, 32'hFFFF_FFFF};
        logic [31:0] r; logic e; int lat, nrd, nwr;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], adr[i], 32'h5A5A_5A5A, r, e, lat, nrd, nwr);
            total++;
            if (e !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || r !== 32'h0) begin
                bad++;
                $display("FAIL err%0d op=%0d addr=%h got err=%b lat=%0d rd=%0d wr=%0d r=%h exp 1 1 0 0 0",
                         i, ops[i], adr[i], e, lat, nrd, nwr, r);
            end
        end
        run_op(OP_LW, 32'd1020, 32'h0, r, e, lat, nrd, nwr);
        total++;
        if (e !== 1'b0 || r !== 32'h0 || lat != 2) begin
            bad++; $display("FAIL lw1020 got err=%b r=%h lat=%0d exp 0 0 2", e, r, lat);
        end
        run_op(OP_LB, 32'd1023, 32'h0, r, e, lat, nrd, nwr);
        total++;
        if (e !== 1'b0 || nrd != 1) begin
            bad++; $display("FAIL lb1023 got err=%b rd=%0d exp 0 1", e, nrd);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] r; logic e; int lat, nrd, nwr;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'd8; req_wdata = 32'hDEAD_BEEF; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (MemWrite !== 1'b1) begin
            bad++; $display("FAIL sw8_write_state got mw=%b exp 1", MemWrite);
        end
        rst = 1'b1;
        #1;
        total++;
        if (MemWrite !== 1'b0 || MemRead !== 1'b0 || addr !== 32'h0 || wd !== 32'h0 ||
            req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset got mw=%b mr=%b addr=%h wd=%h rr=%b rv=%b rd=%h re=%b exp 0 0 0 0 1 0 0 0",
                     MemWrite, MemRead, addr, wd, req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_LW, 32'd8, 32'h0, r, e, lat, nrd, nwr);
        total++;
        if (r !== 32'h1234_5678 || e !== 1'b0) begin
            bad++; $display("FAIL midreset_readback got=%h err=%b exp=12345678 err=0", r, e);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_loads();
        test_backpressure();
        test_sb();
        test_sh_sw();
        test_errors();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
